// File: rtl/mem.sv
// 32 x 64-bit flip-flop register file with a single shared address and a
// write/read mode select. Read is combinational; the whole array clears on reset.
module mem #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              wr_en_s;
    logic [DATA_W-1:0] rd_data_s;

    // An unknown mode must never write, so enable only on an exact 0.
    assign wr_en_s = (mode === 1'b0);

    // Storage array: async clear, single write port on the rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            mem_r[addr] <= data_in;
        end
    end

    // Read mux: zero during reset and write cycles, selected word otherwise.
    always_comb begin
        rd_data_s = '0;
        if (reset) begin
            rd_data_s = '0;
        end else if (wr_en_s) begin
            rd_data_s = '0;
        end else begin
            rd_data_s = mem_r[addr];
        end
    end

    assign data_out = rd_data_s;

endmodule

// File: tb/tb_mem.sv
// Directed self-checking bench for mem: reset clear, sweep, full-width data,
// isolation/overwrite, alternating random traffic and reset on a write edge.
module tb_mem;

    logic        clk;
    logic        reset;
    logic        mode;
    logic [4:0]  addr;
    logic [63:0] data_in;
    logic [63:0] data_out;

    int          errors;
    int          checks;
    logic [63:0] model [32];

    mem dut (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [63:0] d);
        @(negedge clk);
        mode    = 1'b0;
        addr    = a;
        data_in = d;
        #1;
        check("write_cycle_zero", data_out, 64'h0);
        @(posedge clk);
        #1;
        model[a] = d;
    endtask

    task automatic do_read(input string tag, input logic [4:0] a);
        @(negedge clk);
        mode = 1'b1;
        addr = a;
        #1;
        check(tag, data_out, model[a]);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 64'h0;
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        reset   = 1'b1;
        mode    = 1'b1;
        addr    = 5'd0;
        data_in = 64'h0;
        clear_model();

        // Power-up reset
        #2;
        check("reset_out", data_out, 64'h0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) do_read("powerup_zero", 5'(i));

        // Reset pulse between edges clears written data
        do_write(5'd5, 64'hDEAD_BEEF_CAFE_F00D);
        do_read("pre_pulse", 5'd5);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("during_pulse", data_out, 64'h0);
        reset = 1'b0;
        clear_model();
        do_read("post_pulse", 5'd5);

        // Write/read sweep
        for (int i = 0; i < 32; i++) begin
            logic [31:0] lo;
            lo = 32'(i) * 32'h0101_0101;
            do_write(5'(i), {32'h0, lo});
        end
        for (int i = 0; i < 32; i++) do_read("sweep", 5'(i));
        do_read("sweep_hi", 5'd31);
        check("sweep_31_const", data_out, 64'h0000_0000_1F1F_1F1F);

        // Full-width data
        do_write(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        do_write(5'd0,  64'h8000_0000_0000_0001);
        do_read("full_31", 5'd31);
        check("full_31_const", data_out, 64'hFFFF_FFFF_FFFF_FFFF);
        do_read("full_0", 5'd0);
        check("full_0_const", data_out, 64'h8000_0000_0000_0001);

        // Isolation and overwrite
        do_write(5'd3, 64'h1);
        do_write(5'd4, 64'h2);
        do_read("iso_3", 5'd3);
        check("iso_3_const", data_out, 64'h1);
        do_write(5'd3, 64'h3);
        do_read("ovw_3", 5'd3);
        check("ovw_3_const", data_out, 64'h3);
        do_read("ovw_4", 5'd4);
        check("ovw_4_const", data_out, 64'h2);

        // Combinational read follows addr within a cycle
        @(negedge clk);
        mode = 1'b1;
        addr = 5'd31;
        #1;
        check("comb_addr_a", data_out, 64'hFFFF_FFFF_FFFF_FFFF);
        addr = 5'd0;
        #1;
        check("comb_addr_b", data_out, 64'h8000_0000_0000_0001);
        mode = 1'b0;
        #1;
        check("comb_mode_w", data_out, 64'h0);
        mode = 1'b1;

        // Alternating random traffic
        for (int i = 0; i < 10; i++) begin
            logic [63:0] rv;
            rv = {40'h0, 24'($urandom())};
            do_write(5'(10 + i), rv);
            do_read("rand_rd", 5'(10 + i));
        end
        for (int i = 0; i < 32; i++) do_read("rand_final", 5'(i));

        // Reset held across a write edge
        @(negedge clk);
        mode    = 1'b0;
        addr    = 5'd7;
        data_in = 64'hA5A5;
        reset   = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        clear_model();
        do_read("rst_write_7", 5'd7);
        check("rst_write_7_const", data_out, 64'h0);
        do_read("rst_write_31", 5'd31);

        // Normal operation resumes after reset
        do_write(5'd7, 64'h1234_5678_9ABC_DEF0);
        do_read("post_rst_7", 5'd7);
        check("post_rst_7_const", data_out, 64'h1234_5678_9ABC_DEF0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
